mips_multicycle_ctrl: RTL

Control FSM that sequences the MIPS datapath as a multi-cycle machine over one shared instruction/data memory port.
- Emits per-state control strokes: mux selects, ALU op, write enables, PC enable.
- Uses a ready handshake, so slow memory can insert wait states.
- Supports the team's instruction subset: lw, sw, beq, bne, addi, andi, and R-type add/sub/and/or/slt.
- Sits beside the datapath registers (PC, IR, A, B, ALUOut, MDR); opcode/funct come from the IR.

---
 rtl/mips_defs.sv | 43 ++++
 rtl/mips_alu_decoder.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs,
// ALU control codes, ALU B-source selects and controller state encodings.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC_R = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_EXEC_I = 4'd8;
   localparam logic [3:0] S_IWB    = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_TRAP   = 4'd15;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps opcode/funct to an ALU control code; flags R-type functs outside the subset.
module mips_alu_decoder
   import mips_defs::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_valid
);

   always_comb begin
      alu_ctrl    = ALU_ADD;
      funct_valid = 1'b1;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            // Unknown functs fall back to slt when the controller does not trap them.
            default: begin
               alu_ctrl    = ALU_SLT;
               funct_valid = 1'b0;
            end
         endcase
      end else if (opcode == OP_ANDI) begin
         alu_ctrl = ALU_AND;
      end
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM sharing one memory port, with ready-based wait states,
// a sticky trap state and a retired-instruction counter.
module mips_multicycle_ctrl
   import mips_defs::*;
#(
   parameter int unsigned CNT_W             = 32,
   parameter bit          TRAP_ON_BAD_FUNCT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_en,
   output logic             pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_dbg
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic [2:0]       dec_alu_ctrl;
   logic             funct_valid;

   mips_alu_decoder u_alu_decoder (
      .opcode      (opcode),
      .funct       (funct),
      .alu_ctrl    (dec_alu_ctrl),
      .funct_valid (funct_valid)
   );

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     state_d = S_MEMADR;
               OP_RTYPE:         state_d = (TRAP_ON_BAD_FUNCT && !funct_valid) ? S_TRAP
                                                                               : S_EXEC_R;
               OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:   state_d = S_BRANCH;
               default:          state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC_R: state_d = S_RWB;
         S_EXEC_I: state_d = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctrl   = ALU_ADD;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM_SH2;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_ctrl  = dec_alu_ctrl;
         end
         S_RWB: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = dec_alu_ctrl;
         end
         S_IWB: reg_we = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = 1'b1;
            pc_en     = alu_zero ^ (opcode == OP_BNE);
         end
         default: ;
      endcase
      // Reset suppresses every side-effecting strobe so an abandoned access writes nothing.
      if (reset) begin
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         ir_write = 1'b0;
         pc_en    = 1'b0;
         reg_we   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign illegal   = (state_q == S_TRAP);
   assign retired   = retired_q;
   assign state_dbg = state_q;

endmodule
